// File: rtl/alink_txfifo.sv
// alink_txfifo: first-word-fall-through transmit FIFO between the ALINK
// Wishbone slave and the ALINK PHY/serializer.
//   clk, rst      : clock, asynchronous active-high reset
//   txfifo_push   : one-cycle write strobe, txfifo_din carries the word
//   reg_flush     : one-cycle synchronous flush; wins over push and pop
//   txfifo_pop    : consumer takes the current txfifo_dout
//   txfifo_dout   : head word, valid while txempty=0
//   txempty       : no valid head word
//   txfull        : txcnt==DEPTH
//   txcnt         : words held (RAM + output register)
//   txovf         : one-cycle pulse after a push was dropped while full
module alink_txfifo #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10,
  parameter int unsigned CW    = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          txfifo_push,
  input  logic [31:0]   txfifo_din,
  input  logic          reg_flush,
  input  logic          txfifo_pop,
  output logic [31:0]   txfifo_dout,
  output logic          txempty,
  output logic          txfull,
  output logic [CW-1:0] txcnt,
  output logic          txovf
);

  localparam int unsigned DW = 32;

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ov_q, ov_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic [DW-1:0] dout_q, dout_d;

  logic [CW-1:0] ram_cnt;
  logic          push_acc;
  logic          pop_acc;
  logic          load;

  // Acceptance terms; full comes from the registered count, so a same-cycle
  // pop never frees room for a push.
  always_comb begin
    push_acc = txfifo_push & ~full_q & ~reg_flush;
    pop_acc  = txfifo_pop & ov_q & ~reg_flush;
    ram_cnt  = cnt_q - CW'(ov_q);
    // Read-ahead: refill the output register whenever it is free or being
    // emptied this cycle, which sustains one pop per cycle.
    load     = (ram_cnt != '0) & (~ov_q | pop_acc) & ~reg_flush;
  end

  // Next-state for pointers, count, flags and output register.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ov_d     = ov_q;
    dout_d   = dout_q;
    ovf_d    = 1'b0;

    if (reg_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ov_d     = 1'b0;
    end else begin
      ovf_d = txfifo_push & full_q;
      if (push_acc) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (load) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        dout_d   = mem[rd_ptr_q];
        ov_d     = 1'b1;
      end else if (pop_acc) begin
        ov_d = 1'b0;
      end
      case ({push_acc, pop_acc})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    full_d = (cnt_d == CW'(DEPTH));
  end

  // Storage array; contents are not reset.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr_q] <= txfifo_din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ov_q     <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ov_q     <= ov_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      dout_q   <= dout_d;
    end
  end

  assign txfifo_dout = dout_q;
  assign txempty     = ~ov_q;
  assign txfull      = full_q;
  assign txcnt       = cnt_q;
  assign txovf       = ovf_q;

endmodule
